// File: rtl/streamgen_if.sv
// AXI4-Stream bundle for streamgen: master drives valid/data/strb/last, slave drives ready.
interface streamgen_if #(
  parameter int C_AXIS_BYTEWIDTH = 4
);
  logic                          tvalid;
  logic [C_AXIS_BYTEWIDTH*8-1:0] tdata;
  logic [C_AXIS_BYTEWIDTH-1:0]   tstrb;
  logic                          tlast;
  logic                          tready;

  modport master (output tvalid, tdata, tstrb, tlast, input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/streamgen.sv
// Framed AXI-Stream traffic generator (IDLE/SEND/GAP). Counting data by default;
// define STREAMGEN_LFSR_EN for 32-bit Galois LFSR data instead.
module streamgen #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [15:0] num_frames,
  input  logic [7:0]  gap_cycles,
  streamgen_if.master output_m_axis,
  output logic        busy,
  output logic [31:0] beats_sent,
  output logic [31:0] frames_sent
);
  localparam int DW = C_AXIS_BYTEWIDTH * 8;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_q;
  logic [15:0] flen_q, nfr_q, beat_idx_q;
  logic [7:0]  gap_q, gap_cnt_q;
  logic        stop_pend_q;
  logic [31:0] beats_q, frames_q;
  logic [31:0] pat;
  logic [DW-1:0] tdata_w;
  logic        accept, last_beat, quota_met, stop_now;

  assign accept    = (state_q == SEND) && output_m_axis.tready;
  assign last_beat = (beat_idx_q == flen_q - 16'd1);
  assign quota_met = (nfr_q != 16'd0) && (frames_q + 32'd1 == {16'd0, nfr_q});
  assign stop_now  = stop_pend_q || stop;

`ifdef STREAMGEN_LFSR_EN
  // x^32+x^22+x^2+x+1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                      lfsr_q <= '0;
    else if (state_q == IDLE && start) lfsr_q <= '1;
    else if (accept)                  lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  end

  assign pat = lfsr_q;
`else
  assign pat = beats_q;
`endif

  // LFSR words replicate across wide buses; the counter zero-extends
  always_comb begin
    tdata_w = '0;
    for (int i = 0; i < DW; i++) begin
`ifdef STREAMGEN_LFSR_EN
      tdata_w[i] = pat[i % 32];
`else
      if (i < 32) tdata_w[i] = pat[i % 32];
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      flen_q      <= 16'd1;
      nfr_q       <= '0;
      gap_q       <= '0;
      beat_idx_q  <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      beats_q     <= '0;
      frames_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q     <= SEND;
          flen_q      <= (frame_len == 16'd0) ? 16'd1 : frame_len;
          nfr_q       <= num_frames;
          gap_q       <= gap_cycles;
          beat_idx_q  <= '0;
          beats_q     <= '0;
          frames_q    <= '0;
          stop_pend_q <= stop;
        end
        SEND: begin
          if (stop) stop_pend_q <= 1'b1;
          if (accept) begin
            beats_q <= beats_q + 32'd1;
            if (last_beat) begin
              frames_q   <= frames_q + 32'd1;
              beat_idx_q <= '0;
              if (quota_met || stop_now) begin
                state_q     <= IDLE;
                stop_pend_q <= 1'b0;
              end else if (gap_q != 8'd0) begin
                state_q   <= GAP;
                gap_cnt_q <= gap_q;
              end
            end else begin
              beat_idx_q <= beat_idx_q + 16'd1;
            end
          end
        end
        GAP: begin
          if (stop_now) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
          end else if (gap_cnt_q == 8'd1) begin
            state_q <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign output_m_axis.tvalid = (state_q == SEND);
  assign output_m_axis.tlast  = (state_q == SEND) && last_beat;
  assign output_m_axis.tstrb  = {C_AXIS_BYTEWIDTH{state_q == SEND}};
  assign output_m_axis.tdata  = tdata_w;

  assign busy        = (state_q != IDLE);
  assign beats_sent  = beats_q;
  assign frames_sent = frames_q;
endmodule

// File: tb/tb_streamgen.sv
// Directed + randomized bench for streamgen against a beat/frame-level reference model.
module tb_streamgen;
  localparam int BW = 4;
  localparam int DW = BW * 8;

  logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, stop = 1'b0;
  logic [15:0] frame_len = '0, num_frames = '0;
  logic [7:0]  gap_cycles = '0;
  logic        busy;
  logic [31:0] beats_sent, frames_sent;

  int checks = 0, failures = 0;
  int r_cycles;
  logic [31:0] cap [2];

  streamgen_if #(.C_AXIS_BYTEWIDTH(BW)) axis ();

  streamgen #(.C_AXIS_BYTEWIDTH(BW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .frame_len(frame_len), .num_frames(num_frames), .gap_cycles(gap_cycles),
    .output_m_axis(axis), .busy(busy),
    .beats_sent(beats_sent), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Data word the generator should present for the beat following word s.
  function automatic logic [31:0] model_next(input logic [31:0] s);
`ifdef STREAMGEN_LFSR_EN
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 32'h8020_0003;
    return s;
`else
    return s + 32'd1;
`endif
  endfunction

  // One run: start, drive tready, check every beat/gap, then the final counters.
  task automatic run(input int fl, input int nf, input int gp, input bit stop_w_start,
                     input int p_ready, input int stall_beat, input int stall_len,
                     input int stop_at, input bit stop_gap, input int restart_at);
    int fle, k, frames, final_frames, low, cyc, stall_cnt;
    bit gap_pending, stalled, stop_done, restarted, rdy;
    logic [DW:0] held;
    logic [31:0] gen;
    fle = (fl == 0) ? 1 : fl;
    k = 0; frames = 0; low = 0; cyc = 0; stall_cnt = 0;
    gap_pending = 0; stalled = 0; stop_done = 0; restarted = 0; held = '0;
    final_frames = stop_w_start ? 1 : ((nf == 0) ? -1 : nf);
`ifdef STREAMGEN_LFSR_EN
    gen = 32'hFFFF_FFFF;
`else
    gen = 32'd0;
`endif
    @(negedge clk);
    frame_len = 16'(fl); num_frames = 16'(nf); gap_cycles = 8'(gp);
    start = 1'b1; stop = stop_w_start;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("first_valid", 64'(axis.tvalid), 64'd1);
    while (busy && cyc < 3000) begin
      cyc++;
      if (axis.tvalid) begin
        check("tstrb", 64'(axis.tstrb), 64'hF);
        check("tdata", 64'(axis.tdata), 64'(gen));
        check("tlast", 64'(axis.tlast), 64'((k % fle) == fle - 1));
        if (stalled) check("hold", 64'({axis.tdata, axis.tlast}), 64'(held));
        if (gap_pending) begin
          check("gap_len", 64'(low), 64'(gp));
          gap_pending = 0;
        end
        low = 0;
      end else begin
        low++;
      end
      rdy = ($urandom_range(0, 99) < p_ready);
      if (k == stall_beat && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      axis.tready = rdy;
      if (!stop_done && stop_at >= 0 && k >= stop_at && (stop_gap ? !axis.tvalid : axis.tvalid)) begin
        stop = 1'b1;
        stop_done = 1;
        if (final_frames < 0 || final_frames > frames + int'(axis.tvalid))
          final_frames = frames + int'(axis.tvalid);
      end
      if (!restarted && restart_at >= 0 && k == restart_at) begin
        start = 1'b1; frame_len = 16'd7; num_frames = 16'd1; gap_cycles = 8'd0;
        restarted = 1;
      end
      if (axis.tvalid) begin
        stalled = !rdy;
        held = {axis.tdata, axis.tlast};
        if (rdy) begin
          if (k < 2) cap[k] = axis.tdata;
          if ((k % fle) == fle - 1) begin
            frames++;
            gap_pending = 1;
          end
          k++;
          gen = model_next(gen);
        end
      end else begin
        stalled = 0;
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
    end
    r_cycles = cyc;
    check("run_ends", 64'(busy), 64'd0);
    check("frames_seen", 64'(frames), 64'(final_frames));
    check("beats_model", 64'(k), 64'(final_frames * fle));
    repeat (3) begin
      check("idle_tvalid", 64'(axis.tvalid), 64'd0);
      @(negedge clk);
    end
    check("beats_sent", 64'(beats_sent), 64'(k));
    check("frames_sent", 64'(frames_sent), 64'(final_frames));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl, nf, gp, p, sa;
    axis.tready = 1'b1;
    #3;
    check("rst_tvalid", 64'(axis.tvalid), 64'd0);
    check("rst_tlast", 64'(axis.tlast), 64'd0);
    check("rst_tdata", 64'(axis.tdata), 64'd0);
    check("rst_tstrb", 64'(axis.tstrb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'({beats_sent, frames_sent}), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Back-to-back frames with tready always high
    run(4, 2, 0, 0, 100, -1, 0, -1, 0, -1);
    check("b2b_cycles", 64'(r_cycles), 64'd8);

    // Stall on the second beat
    run(3, 1, 0, 0, 100, 1, 5, -1, 0, -1);
    check("stall_cycles", 64'(r_cycles), 64'd8);

    // Unlimited frames with gaps, stopped mid-frame
    run(2, 0, 3, 0, 70, -1, 0, 4, 0, -1);

    // frame_len 0 acts as 1; start while busy is ignored
    run(0, 5, 1, 0, 80, -1, 0, -1, 0, 2);

    // start+stop together sends exactly one frame
    run(3, 0, 2, 1, 100, -1, 0, -1, 0, -1);

    // stop during a gap ends the run on the next cycle
    run(2, 0, 5, 0, 100, -1, 0, 2, 1, -1);
    check("gap_stop_cycles", 64'(r_cycles), 64'd3);

    // stop in IDLE must not leave a pending stop behind
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    run(1, 2, 0, 0, 100, -1, 0, -1, 0, -1);

    // First two data words of a fresh run
    run(2, 1, 0, 0, 100, -1, 0, -1, 0, -1);
`ifdef STREAMGEN_LFSR_EN
    check("word0", 64'(cap[0]), 64'hFFFF_FFFF);
    check("word1", 64'(cap[1]), 64'hFFDF_FFFC);
`else
    check("word0", 64'(cap[0]), 64'd0);
    check("word1", 64'(cap[1]), 64'd1);
`endif

    for (int i = 0; i < 6; i++) begin
      fl = int'($urandom_range(0, 5));
      nf = int'($urandom_range(1, 4));
      gp = int'($urandom_range(0, 3));
      p  = int'($urandom_range(30, 100));
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
      run(fl, nf, gp, 0, p, -1, 0, sa, 0, -1);
    end

    // Asynchronous reset in the middle of a frame
    @(negedge clk);
    frame_len = 16'd8; num_frames = 16'd1; gap_cycles = 8'd0; start = 1'b1;
    axis.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_beats", 64'(beats_sent), 64'd3);
    check("pre_rst_valid", 64'(axis.tvalid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(axis.tvalid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cnt", 64'({beats_sent, frames_sent}), 64'd0);
    check("arst_tlast_strb", 64'({axis.tlast, axis.tstrb}), 64'd0);
    check("arst_tdata", 64'(axis.tdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", 64'({axis.tvalid, busy}), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
